cp0_regfile: RTL and testbench
==============================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL have these ports (name direction width meaning):
  clk  in  1  sole clock, rising edge.
  rst  in  1  reset, asynchronous, active-low.
  we_i  in  1  MTC0 write enable, execute stage (cp0write_enE).
  waddr_i  in  5  MTC0 destination register number.
  raddr_i  in  5  MFC0 source register number.
  wdata_i  in  32  MTC0 data.
  int_i  in  6  external hardware interrupt lines.
  haveException_i  in  1  exception present in execute stage (haveExceptionE).
  exceptionType_i  in  32  exception code (exceptionTypeE).
  pc_i  in  32  PC of the excepting instruction (pcE).
  isDelaySlot_i  in  1  excepting instruction is in a delay slot.
  badAddr_i  in  32  faulting address (badAddrE).
  rdata_o  out  32  MFC0 read data.
  status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o  out  32 each  live register values.
  timer_int_o  out  1  timer interrupt pending.
  int_pending_o  out  1  enabled interrupt pending.
  flush_o  out  1  pipeline flush request.
  newpc_o  out  32  redirect target, valid when flush_o=1.

Function
REQ-002 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14) and PRId(15). PRId SHALL read as constant 0x00004220.
REQ-003 SHALL return 0 in rdata_o for an unimplemented raddr_i.
REQ-004 SHALL drive rdata_o combinationally. If we_i=1 and waddr_i==raddr_i, rdata_o SHALL return the value the register holds after the write commits.
REQ-005 SHALL use these exception codes: 0x01 interrupt, 0x04 AdEL, 0x05 AdES, 0x08 Sys, 0x09 Bp, 0x0a RI, 0x0c Ov, 0x0e ERET.
  - Cause.ExcCode[6:2] SHALL take exceptionType_i[4:0].
  - ERET SHALL NOT write Cause.
REQ-006 Status write mask: only IM[15:8], EXL[1] and IE[0] are writable. BEV[22] SHALL be fixed at 1. All other bits SHALL read 0.
REQ-007 Cause write mask: only IP[9:8] are writable.
REQ-008 Cause.IP[15:10] SHALL be registered every cycle from int_i[5:0], with IP[15] OR'd with timer_int_o.
REQ-009 BadVAddr SHALL be read-only to MTC0. EPC, Count and Compare SHALL be fully writable.
REQ-010 Count SHALL increment by 1 every second clk cycle via an internal toggle bit. Count SHALL wrap from 0xFFFFFFFF to 0.
REQ-011 An MTC0 write to Count SHALL load wdata_i and clear the toggle bit. The write SHALL take priority over the increment.
REQ-012 timer_int_o SHALL be set on the cycle after Count==Compare with Compare!=0. It SHALL hold until an MTC0 write to Compare clears it.
REQ-013 int_pending_o = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL, combinational.
REQ-014 On haveException_i=1 with a non-ERET code:
  - If Status.EXL=0: EPC <= isDelaySlot_i ? pc_i-4 : pc_i, and Cause.BD[31] <= isDelaySlot_i.
  - If Status.EXL=1: EPC and BD SHALL be unchanged.
  - In both cases: Status.EXL <= 1 and ExcCode updated.
REQ-015 For AdEL/AdES, BadVAddr <= badAddr_i. Other codes SHALL leave BadVAddr unchanged.
REQ-016 On ERET, Status.EXL <= 0.
REQ-017 flush_o SHALL equal haveException_i, combinationally in the same cycle.
  - newpc_o = 0xBFC00380 for non-ERET codes.
  - newpc_o = current EPC for ERET.
  - newpc_o = 0 when there is no exception.
REQ-018 When haveException_i=1 and we_i=1 in the same cycle, the exception update SHALL commit and the MTC0 write SHALL be discarded.
REQ-019 All register updates SHALL take effect on the rising clk edge. Read-back SHALL be visible the following cycle, except as stated in REQ-004.

Reset
REQ-020 While rst=0, asynchronously:
  - Status=0x00400000.
  - Cause, EPC, BadVAddr, Count, Compare and the toggle bit = 0.
  - timer_int_o=0.
  - Outputs SHALL reflect these values immediately.
REQ-021 Reset asserted mid-exception SHALL override all updates. No partial EXL or EPC state SHALL survive.
REQ-022 After rst rises, Count SHALL first read 1 two clk edges later.

Verification
REQ-023 Reset and count: release reset, run 10 cycles -> count_o=5, status_o=0x00400000, rdata_o(raddr=15)=0x00004220.
REQ-024 Timer:
  - Write Compare=8 and Count=0 -> timer_int_o=1 one cycle after Count reaches 8, and cause_o[15]=1.
  - Then write Compare=0x20 -> timer_int_o=0 next cycle.
REQ-025 Delay-slot overflow: haveException_i=1, type=0x0c, pc_i=0xBFC00104, isDelaySlot_i=1 -> same cycle flush_o=1, newpc_o=0xBFC00380; next cycle epc_o=0xBFC00100, cause_o[31]=1, cause_o[6:2]=0x0c, status_o[1]=1.
REQ-026 AdEL then ERET:
  - type=0x04, badAddr_i=0x80000003 -> badvaddr_o=0x80000003.
  - A subsequent ERET -> newpc_o=EPC, flush_o=1, and status_o[1]=0 next cycle.
REQ-027 Collision and mask:
  - we_i=1 to EPC with haveException_i=1 in the same cycle -> EPC holds the exception PC.
  - MTC0 Status=0xFFFFFFFF -> status_o=0x0040FF03.
REQ-028 Interrupt: Status=0x0000FF01, int_i=6'b000001 -> int_pending_o=1 one cycle later. Setting EXL=1 -> int_pending_o=0.

Source files
------------

// File: rtl/cp0_regfile_if.sv
// Signal bundle between the execute stage and the CP0 register file:
// MTC0/MFC0 access, exception report, interrupt lines and live register taps.
interface cp0_regfile_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] wdata_i;
  logic [5:0]  int_i;
  logic        haveException_i;
  logic [31:0] exceptionType_i;
  logic [31:0] pc_i;
  logic        isDelaySlot_i;
  logic [31:0] badAddr_i;
  logic [31:0] rdata_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] badvaddr_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic        timer_int_o;
  logic        int_pending_o;
  logic        flush_o;
  logic [31:0] newpc_o;

  modport master (
    output we_i, waddr_i, raddr_i, wdata_i, int_i, haveException_i,
           exceptionType_i, pc_i, isDelaySlot_i, badAddr_i,
    input  rdata_o, status_o, cause_o, epc_o, badvaddr_o, count_o,
           compare_o, timer_int_o, int_pending_o, flush_o, newpc_o
  );

  modport slave (
    input  we_i, waddr_i, raddr_i, wdata_i, int_i, haveException_i,
           exceptionType_i, pc_i, isDelaySlot_i, badAddr_i,
    output rdata_o, status_o, cause_o, epc_o, badvaddr_o, count_o,
           compare_o, timer_int_o, int_pending_o, flush_o, newpc_o
  );
endinterface

// File: rtl/cp0_regfile.sv
// MIPS-style CP0 register file: Status/Cause/EPC/BadVAddr/Count/Compare/PRId,
// exception entry and ERET, timer interrupt and pending-interrupt detection.
module cp0_regfile (
  input  logic         clk,
  input  logic         rst,
  cp0_regfile_if.slave bus
);
  localparam logic [31:0] PRID_VAL   = 32'h0000_4220;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [31:0] EXC_ADEL   = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES   = 32'h0000_0005;
  localparam logic [31:0] EXC_ERET   = 32'h0000_000E;
  localparam logic [4:0]  R_BADVADDR = 5'd8;
  localparam logic [4:0]  R_COUNT    = 5'd9;
  localparam logic [4:0]  R_COMPARE  = 5'd11;
  localparam logic [4:0]  R_STATUS   = 5'd12;
  localparam logic [4:0]  R_CAUSE    = 5'd13;
  localparam logic [4:0]  R_EPC      = 5'd14;
  localparam logic [4:0]  R_PRID     = 5'd15;

  function automatic logic [31:0] pack_status(input logic [7:0] im, input logic exl,
                                              input logic ie);
    return {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip_hw,
                                             input logic timer, input logic [1:0] ip_sw,
                                             input logic [4:0] exc);
    return {bd, 15'd0, ip_hw[5] | timer, ip_hw[4:0], ip_sw, 1'b0, exc, 2'd0};
  endfunction

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        tick_q, tick_d, timer_q, timer_d;
  logic        is_eret_s, bypass_s;
  logic [31:0] status_q_s, status_d_s, cause_q_s, cause_d_s, rdata_s;

  assign is_eret_s  = (bus.exceptionType_i == EXC_ERET);
  assign status_q_s = pack_status(im_q, exl_q, ie_q);
  assign status_d_s = pack_status(im_d, exl_d, ie_d);
  assign cause_q_s  = pack_cause(bd_q, ip_hw_q, timer_q, ip_sw_q, exc_code_q);
  assign cause_d_s  = pack_cause(bd_d, ip_hw_d, timer_d, ip_sw_d, exc_code_d);

  // Next-state: free-running count/timer, then exception or MTC0 (exception wins).
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    ip_hw_d    = bus.int_i;
    tick_d     = ~tick_q;
    if (tick_q) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      timer_d = 1'b1;
    end else begin
      timer_d = timer_q;
    end

    if (bus.haveException_i) begin
      if (is_eret_s) begin
        exl_d = 1'b0;
      end else begin
        // A nested exception keeps the EPC/BD of the original one.
        if (!exl_q) begin
          epc_d = bus.isDelaySlot_i ? (bus.pc_i - 32'd4) : bus.pc_i;
          bd_d  = bus.isDelaySlot_i;
        end else begin
          epc_d = epc_q;
        end
        exl_d      = 1'b1;
        exc_code_d = bus.exceptionType_i[4:0];
        if ((bus.exceptionType_i == EXC_ADEL) || (bus.exceptionType_i == EXC_ADES)) begin
          badvaddr_d = bus.badAddr_i;
        end else begin
          badvaddr_d = badvaddr_q;
        end
      end
    end else if (bus.we_i) begin
      case (bus.waddr_i)
        R_COUNT: begin
          count_d = bus.wdata_i;
          tick_d  = 1'b0;
        end
        R_COMPARE: begin
          compare_d = bus.wdata_i;
          timer_d   = 1'b0;
        end
        R_STATUS: begin
          im_d  = bus.wdata_i[15:8];
          exl_d = bus.wdata_i[1];
          ie_d  = bus.wdata_i[0];
        end
        R_CAUSE: ip_sw_d = bus.wdata_i[9:8];
        R_EPC:   epc_d   = bus.wdata_i;
        default: ip_sw_d = ip_sw_q;
      endcase
    end else begin
      exl_d = exl_q;
    end
  end

  // MFC0 read port; a same-cycle write to the read register returns its committed value.
  always_comb begin
    bypass_s = bus.we_i && (bus.waddr_i == bus.raddr_i);
    case (bus.raddr_i)
      R_BADVADDR: rdata_s = bypass_s ? badvaddr_d : badvaddr_q;
      R_COUNT:    rdata_s = bypass_s ? count_d    : count_q;
      R_COMPARE:  rdata_s = bypass_s ? compare_d  : compare_q;
      R_STATUS:   rdata_s = bypass_s ? status_d_s : status_q_s;
      R_CAUSE:    rdata_s = bypass_s ? cause_d_s  : cause_q_s;
      R_EPC:      rdata_s = bypass_s ? epc_d      : epc_q;
      R_PRID:     rdata_s = PRID_VAL;
      default:    rdata_s = 32'd0;
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      tick_q     <= 1'b0;
      timer_q    <= 1'b0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      tick_q     <= tick_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.rdata_o       = rdata_s;
  assign bus.status_o      = status_q_s;
  assign bus.cause_o       = cause_q_s;
  assign bus.epc_o         = epc_q;
  assign bus.badvaddr_o    = badvaddr_q;
  assign bus.count_o       = count_q;
  assign bus.compare_o     = compare_q;
  assign bus.timer_int_o   = timer_q;
  assign bus.int_pending_o = (|(cause_q_s[15:8] & im_q)) & ie_q & ~exl_q;
  assign bus.flush_o       = bus.haveException_i;
  assign bus.newpc_o       = !bus.haveException_i ? 32'd0 :
                             (is_eret_s ? epc_q : EXC_VECTOR);
endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus random traffic
// compared every cycle against a word-level architectural model.
module tb_cp0_regfile;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  cp0_regfile_if bus ();
  cp0_regfile dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // cs holds only BD, software IP and ExcCode; count = cbase + age/2.
  typedef struct packed {
    logic [31:0] st;
    logic [31:0] cs;
    logic [31:0] epc;
    logic [31:0] bad;
    logic [31:0] cbase;
    int unsigned age;
    logic [31:0] cmp;
    logic        timer;
    logic [5:0]  iphw;
  } model_t;

  model_t m;

  function automatic model_t m_reset();
    model_t r;
    r = '0;
    return r;
  endfunction

  function automatic logic [31:0] m_count(model_t s);
    return s.cbase + 32'(s.age / 2);
  endfunction

  function automatic logic [31:0] m_status(model_t s);
    return s.st | 32'h0040_0000;
  endfunction

  function automatic logic [31:0] m_cause(model_t s);
    return s.cs | {16'd0, s.iphw[5] | s.timer, s.iphw[4:0], 10'd0};
  endfunction

  function automatic model_t m_next(model_t s);
    model_t n;
    logic [31:0] t;
    n = s;
    t = bus.exceptionType_i;
    n.iphw = bus.int_i;
    n.age  = s.age + 1;
    if (m_count(s) == s.cmp && s.cmp != 32'd0) n.timer = 1'b1;
    if (bus.haveException_i) begin
      if (t == 32'h0E) begin
        n.st[1] = 1'b0;
      end else begin
        if (!s.st[1]) begin
          n.epc    = bus.isDelaySlot_i ? bus.pc_i - 32'd4 : bus.pc_i;
          n.cs[31] = bus.isDelaySlot_i;
        end
        n.st[1]   = 1'b1;
        n.cs[6:2] = t[4:0];
        if (t == 32'h04 || t == 32'h05) n.bad = bus.badAddr_i;
      end
    end else if (bus.we_i) begin
      case (bus.waddr_i)
        5'd9:    begin n.cbase = bus.wdata_i; n.age = 0; end
        5'd11:   begin n.cmp = bus.wdata_i; n.timer = 1'b0; end
        5'd12:   n.st = bus.wdata_i & 32'h0000_FF03;
        5'd13:   n.cs = (s.cs & ~32'h0000_0300) | (bus.wdata_i & 32'h0000_0300);
        5'd14:   n.epc = bus.wdata_i;
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] m_read(model_t s, logic [4:0] a);
    case (a)
      5'd8:    return s.bad;
      5'd9:    return m_count(s);
      5'd11:   return s.cmp;
      5'd12:   return m_status(s);
      5'd13:   return m_cause(s);
      5'd14:   return s.epc;
      5'd15:   return 32'h0000_4220;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] st, cs, np, rd;
    logic        pend;
    st   = m_status(m);
    cs   = m_cause(m);
    pend = (|(cs[15:8] & st[15:8])) & st[0] & ~st[1];
    np   = !bus.haveException_i ? 32'd0 :
           (bus.exceptionType_i == 32'h0E ? m.epc : 32'hBFC0_0380);
    rd   = (bus.we_i && bus.waddr_i == bus.raddr_i) ? m_read(m_next(m), bus.raddr_i)
                                                    : m_read(m, bus.raddr_i);
    chk("status", bus.status_o, st);
    chk("cause", bus.cause_o, cs);
    chk("epc", bus.epc_o, m.epc);
    chk("badvaddr", bus.badvaddr_o, m.bad);
    chk("count", bus.count_o, m_count(m));
    chk("compare", bus.compare_o, m.cmp);
    chk("timer_int", {31'd0, bus.timer_int_o}, {31'd0, m.timer});
    chk("int_pending", {31'd0, bus.int_pending_o}, {31'd0, pend});
    chk("flush", {31'd0, bus.flush_o}, {31'd0, bus.haveException_i});
    chk("newpc", bus.newpc_o, np);
    chk("rdata", bus.rdata_o, rd);
  endtask

  task automatic idle();
    bus.we_i = 1'b0; bus.waddr_i = 5'd0; bus.raddr_i = 5'd0; bus.wdata_i = 32'd0;
    bus.haveException_i = 1'b0; bus.exceptionType_i = 32'd0; bus.pc_i = 32'd0;
    bus.isDelaySlot_i = 1'b0; bus.badAddr_i = 32'd0;
  endtask

  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    m = m_next(m);
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    bus.we_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d; bus.raddr_i = a;
    cycle();
  endtask

  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                     input logic [31:0] ba);
    idle();
    bus.haveException_i = 1'b1; bus.exceptionType_i = t; bus.pc_i = pc;
    bus.isDelaySlot_i = ds; bus.badAddr_i = ba;
  endtask

  logic [31:0] types [8] = '{32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0A, 32'h0C, 32'h0E};
  logic [4:0]  wregs [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

  initial begin
    rst = 1'b0;
    bus.int_i = 6'd0;
    idle();
    m = m_reset();
    repeat (2) @(negedge clk);
    #1 check_all();
    chk("reset_status", bus.status_o, 32'h0040_0000);
    rst = 1'b1;

    // Reset release and free-running count
    bus.raddr_i = 5'd15;
    repeat (10) cycle();
    #1;
    chk("req023_count", bus.count_o, 32'd5);
    chk("req023_status", bus.status_o, 32'h0040_0000);
    chk("req023_prid", bus.rdata_o, 32'h0000_4220);

    // Timer interrupt
    mtc0(5'd11, 32'd8);
    mtc0(5'd9, 32'd0);
    idle();
    repeat (20) cycle();
    chk("timer_set", {31'd0, bus.timer_int_o}, 32'd1);
    chk("timer_cause15", {31'd0, bus.cause_o[15]}, 32'd1);
    mtc0(5'd11, 32'h20);
    chk("timer_clear", {31'd0, bus.timer_int_o}, 32'd0);

    // Delay-slot overflow
    exc(32'h0C, 32'hBFC0_0104, 1'b1, 32'd0);
    #1;
    chk("ov_flush", {31'd0, bus.flush_o}, 32'd1);
    chk("ov_newpc", bus.newpc_o, 32'hBFC0_0380);
    cycle();
    idle();
    #1;
    chk("ov_epc", bus.epc_o, 32'hBFC0_0100);
    chk("ov_bd", {31'd0, bus.cause_o[31]}, 32'd1);
    chk("ov_exccode", {27'd0, bus.cause_o[6:2]}, 32'h0C);
    chk("ov_exl", {31'd0, bus.status_o[1]}, 32'd1);

    // AdEL then ERET
    exc(32'h04, 32'h8000_0040, 1'b0, 32'h8000_0003);
    cycle();
    idle();
    #1 chk("adel_badvaddr", bus.badvaddr_o, 32'h8000_0003);
    exc(32'h0E, 32'd0, 1'b0, 32'd0);
    #1;
    chk("eret_newpc", bus.newpc_o, 32'hBFC0_0100);
    chk("eret_flush", {31'd0, bus.flush_o}, 32'd1);
    cycle();
    idle();
    #1 chk("eret_exl", {31'd0, bus.status_o[1]}, 32'd0);

    // Collision: exception beats MTC0 to EPC
    exc(32'h08, 32'h8000_1000, 1'b0, 32'd0);
    bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.wdata_i = 32'h1234_5678;
    cycle();
    idle();
    #1 chk("collide_epc", bus.epc_o, 32'h8000_1000);
    exc(32'h0E, 32'd0, 1'b0, 32'd0);
    cycle();
    mtc0(5'd12, 32'hFFFF_FFFF);
    #1 chk("status_mask", bus.status_o, 32'h0040_FF03);

    // Interrupt pending
    bus.int_i = 6'b000001;
    mtc0(5'd12, 32'h0000_FF01);
    #1 chk("int_pending_on", {31'd0, bus.int_pending_o}, 32'd1);
    mtc0(5'd12, 32'h0000_FF03);
    #1 chk("int_pending_exl", {31'd0, bus.int_pending_o}, 32'd0);
    bus.int_i = 6'd0;

    // Reset asserted in the middle of an exception cycle
    exc(32'h0C, 32'h8000_2000, 1'b0, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_status", bus.status_o, 32'h0040_0000);
    chk("rst_mid_epc", bus.epc_o, 32'd0);
    chk("rst_mid_cause", bus.cause_o, 32'd0);
    @(posedge clk);
    @(negedge clk);
    idle();
    m = m_reset();
    #1 check_all();
    rst = 1'b1;

    // Random traffic against the model
    for (int k = 0; k < 500; k++) begin
      idle();
      bus.int_i = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      bus.haveException_i = ($urandom_range(0, 7) == 0);
      bus.exceptionType_i = types[$urandom_range(0, 7)];
      bus.pc_i = $urandom;
      bus.isDelaySlot_i = 1'($urandom);
      bus.badAddr_i = $urandom;
      bus.we_i = ($urandom_range(0, 2) == 0);
      bus.waddr_i = ($urandom_range(0, 7) == 0) ? 5'($urandom) : wregs[$urandom_range(0, 6)];
      bus.wdata_i = $urandom;
      if (bus.waddr_i == 5'd11 && $urandom_range(0, 1) == 1)
        bus.wdata_i = m_count(m) + 32'($urandom_range(0, 6));
      if (bus.waddr_i == 5'd9 && $urandom_range(0, 2) == 0)
        bus.wdata_i = 32'hFFFF_FFFC;
      bus.raddr_i = ($urandom_range(0, 1) == 1) ? bus.waddr_i : 5'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
